// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and multi-issue decode.
// Multi-lane push with back-pressure, multi-lane pop, flush on redirect and a sticky over-pop flag.
module fetch_queue #(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned INST_W = 32,
    parameter int unsigned PC_W   = 64,
    parameter int unsigned PUSH_N = 2,
    parameter int unsigned POP_N  = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [PUSH_N-1:0]            push_valid,
    input  logic [PUSH_N*INST_W-1:0]     push_data,
    input  logic [PC_W-1:0]              push_pc,
    output logic                         push_ready,
    output logic [POP_N-1:0]             head_valid,
    output logic [POP_N*INST_W-1:0]      head_inst,
    output logic [POP_N*PC_W-1:0]        head_pc,
    input  logic [$clog2(POP_N+1)-1:0]   pop_count,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         pop_err
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH+1);
    localparam int unsigned PopW = $clog2(POP_N+1);

    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PC_W-1:0]   pc_mem   [DEPTH];

    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic            pop_err_q, pop_err_d;

    logic [CntW-1:0] push_n, push_acc, pop_req, pop_eff;
    logic            seen_zero, pop_over;
    logic [PtrW-1:0] rd_idx [POP_N];

    // Lanes count only up to the first cleared valid bit.
    always_comb begin
        push_n    = '0;
        seen_zero = 1'b0;
        for (int i = 0; i < int'(PUSH_N); i++) begin
            if (!push_valid[i]) begin
                seen_zero = 1'b1;
            end else if (!seen_zero) begin
                push_n = push_n + CntW'(1);
            end
        end
    end

    // Ready depends on registered count only; a same-cycle pop never frees space.
    assign push_ready = (count_q <= CntW'(DEPTH - PUSH_N));
    assign push_acc   = push_ready ? push_n : '0;

    always_comb begin
        pop_req  = (pop_count > PopW'(POP_N)) ? CntW'(POP_N) : CntW'(pop_count);
        pop_eff  = (pop_req > count_q) ? count_q : pop_req;
        pop_over = (CntW'(pop_count) > count_q) || (pop_count > PopW'(POP_N));
    end

    always_comb begin
        head_d    = head_q + PtrW'(pop_eff);
        tail_d    = tail_q + PtrW'(push_acc);
        count_d   = count_q + push_acc - pop_eff;
        pop_err_d = pop_err_q | pop_over;
        if (flush) begin
            head_d    = '0;
            tail_d    = '0;
            count_d   = '0;
            pop_err_d = pop_err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            pop_err_q <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            pop_err_q <= pop_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            for (int i = 0; i < int'(PUSH_N); i++) begin
                if (CntW'(i) < push_acc) begin
                    inst_mem[tail_q + PtrW'(i)] <= push_data[i*INST_W +: INST_W];
                    pc_mem[tail_q + PtrW'(i)]   <= push_pc + PC_W'(4 * i);
                end
            end
        end
    end

    // Read side is purely combinational from registered state: zero read latency.
    always_comb begin
        head_valid = '0;
        head_inst  = '0;
        head_pc    = '0;
        for (int i = 0; i < int'(POP_N); i++) begin
            rd_idx[i]     = head_q + PtrW'(i);
            head_valid[i] = (CntW'(i) < count_q);
            if (head_valid[i]) begin
                head_inst[i*INST_W +: INST_W] = inst_mem[rd_idx[i]];
                head_pc[i*PC_W +: PC_W]       = pc_mem[rd_idx[i]];
            end
        end
    end

    assign count   = count_q;
    assign empty   = (count_q == '0);
    assign full    = (count_q == CntW'(DEPTH));
    assign pop_err = pop_err_q;

endmodule
